// File: rtl/alu_pkg.sv
//============================================================================
// Module : alu_pkg
// Brief  : Shared ALU opcode constants and arbiter FSM state encoding.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_OR     = 4'b0101;
    localparam logic [3:0] ALU_AND    = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_LUI    = 4'b1010;
    localparam logic [3:0] ALU_OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
//============================================================================
// Module : alu
// Brief  : Combinational 32-bit ALU; illegal opcodes give zero and an error.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic [31:0] i_opA,
    input  logic [31:0] i_opB,
    input  logic [3:0]  i_aluOp,
    output logic [31:0] o_result,
    output logic        o_err
);

    logic [4:0] w_shamt;
    assign w_shamt = i_opB[4:0];

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_aluOp)
            ALU_ADD:  o_result = i_opA + i_opB;
            ALU_SUB:  o_result = i_opA - i_opB;
            ALU_SLT:  o_result = {31'b0, $signed(i_opA) < $signed(i_opB)};
            ALU_SLTU: o_result = {31'b0, i_opA < i_opB};
            ALU_XOR:  o_result = i_opA ^ i_opB;
            ALU_OR:   o_result = i_opA | i_opB;
            ALU_AND:  o_result = i_opA & i_opB;
            ALU_SLL:  o_result = i_opA << w_shamt;
            ALU_SRL:  o_result = i_opA >> w_shamt;
            ALU_SRA:  o_result = $signed(i_opA) >>> w_shamt;
            // Operand B carries the already-positioned upper immediate.
            ALU_LUI:  o_result = i_opB;
            default:  o_err    = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
//============================================================================
// Module : alu_arbiter
// Brief  : Two-requester round-robin front end for a shared registered ALU.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_opA,
    input  logic [31:0] i_req0_opB,
    input  logic [3:0]  i_req0_aluOp,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_opA,
    input  logic [31:0] i_req1_opB,
    input  logic [3:0]  i_req1_aluOp,
    output logic        o_req1_ready,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id,
    output logic        o_rsp_err,
    output logic        o_busy
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_prio;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [3:0]  r_aluOp;
    logic        r_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_id;
    logic        r_rsp_err;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [31:0] w_alu_result;
    logic        w_alu_err;

    // A requester wins if it holds priority or the other side is idle.
    assign w_grant0 = i_req0_valid & (~r_prio | ~i_req1_valid);
    assign w_grant1 = i_req1_valid & ( r_prio | ~i_req0_valid);
    assign w_accept = w_ready0 | w_ready1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready0 = w_grant0 & ~i_reset;
                w_ready1 = w_grant1 & ~i_reset;
                if (w_ready0 | w_ready1) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prio     <= 1'b0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_aluOp    <= '0;
            r_id       <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opA   <= w_ready1 ? i_req1_opA   : i_req0_opA;
                r_opB   <= w_ready1 ? i_req1_opB   : i_req0_opB;
                r_aluOp <= w_ready1 ? i_req1_aluOp : i_req0_aluOp;
                r_id    <= w_ready1;
                r_prio  <= ~w_ready1;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= w_alu_result;
                r_rsp_id   <= r_id;
                r_rsp_err  <= w_alu_err;
            end
        end
    end

    alu u_alu (
        .i_opA    (r_opA),
        .i_opB    (r_opB),
        .i_aluOp  (r_aluOp),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    assign o_req0_ready = w_ready0;
    assign o_req1_ready = w_ready1;
    assign o_rsp_valid  = (r_state == ST_RESP);
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_err    = r_rsp_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench for alu_arbiter with a timeline reference model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req0_valid = 1'b0;
    logic [31:0] i_req0_opA = '0;
    logic [31:0] i_req0_opB = '0;
    logic [3:0]  i_req0_aluOp = '0;
    logic        o_req0_ready;
    logic        i_req1_valid = 1'b0;
    logic [31:0] i_req1_opA = '0;
    logic [31:0] i_req1_opB = '0;
    logic [3:0]  i_req1_aluOp = '0;
    logic        o_req1_ready;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_data;
    logic        o_rsp_id;
    logic        o_rsp_err;
    logic        o_busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    alu_arbiter dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req0_valid (i_req0_valid),
        .i_req0_opA   (i_req0_opA),
        .i_req0_opB   (i_req0_opB),
        .i_req0_aluOp (i_req0_aluOp),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_opA   (i_req1_opA),
        .i_req1_opB   (i_req1_opB),
        .i_req1_aluOp (i_req1_aluOp),
        .o_req1_ready (o_req1_ready),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_err    (o_rsp_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    // {err, result} straight from the opcode table.
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return {1'b0, a + b};
            4'd1:    return {1'b0, a - b};
            4'd2:    return {1'b0, 31'b0, ($signed(a) < $signed(b))};
            4'd3:    return {1'b0, 31'b0, (a < b)};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {1'b0, a & b};
            4'd7:    return {1'b0, a << b[4:0]};
            4'd8:    return {1'b0, a >> b[4:0]};
            4'd9:    return {1'b0, 32'($signed(a) >>> b[4:0])};
            4'd10:   return {1'b0, b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Reference: an operation is "in flight" from acceptance until taken;
    // m_since counts cycles since acceptance, result visible from 2 on.
    bit          m_inflight = 1'b0;
    int          m_since    = 0;
    bit          m_prio     = 1'b0;
    bit          m_acc0     = 1'b0;
    bit          m_acc1     = 1'b0;
    logic [32:0] m_pend     = '0;
    bit          m_pend_id  = 1'b0;
    logic [31:0] m_data     = '0;
    bit          m_id       = 1'b0;
    bit          m_err      = 1'b0;

    always @(posedge i_clk) begin
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        if (i_reset) begin
            m_inflight = 1'b0;
            m_prio     = 1'b0;
            m_data     = '0;
            m_id       = 1'b0;
            m_err      = 1'b0;
        end else if (!m_inflight) begin
            if (i_req0_valid && (m_prio == 1'b0 || !i_req1_valid)) begin
                m_acc0 = 1'b1;
                m_pend = alu_ref(i_req0_aluOp, i_req0_opA, i_req0_opB);
                m_pend_id = 1'b0;
            end else if (i_req1_valid) begin
                m_acc1 = 1'b1;
                m_pend = alu_ref(i_req1_aluOp, i_req1_opA, i_req1_opB);
                m_pend_id = 1'b1;
            end
            if (m_acc0 || m_acc1) begin
                m_inflight = 1'b1;
                m_since    = 1;
                m_prio     = ~m_pend_id;
            end
        end else if (m_since == 1) begin
            m_data  = m_pend[31:0];
            m_err   = m_pend[32];
            m_id    = m_pend_id;
            m_since = 2;
        end else if (i_rsp_ready) begin
            m_inflight = 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("ready0", o_req0_ready,
                  !i_reset && !m_inflight && i_req0_valid && (m_prio == 1'b0 || !i_req1_valid));
            check("ready1", o_req1_ready,
                  !i_reset && !m_inflight && i_req1_valid && (m_prio == 1'b1 || !i_req0_valid));
            check("rsp_valid", o_rsp_valid, m_inflight && m_since >= 2);
            check("busy", o_busy, m_inflight);
            check("rsp_data", o_rsp_data, m_data);
            check("rsp_id", o_rsp_id, m_id);
            check("rsp_err", o_rsp_err, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_reset      = 1'b1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_rsp_ready  = 1'b1;
        tick;
        tick;
        i_reset = 1'b0;
    endtask

    task automatic set_req(input bit idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (idx) begin
            i_req1_valid = 1'b1; i_req1_aluOp = op; i_req1_opA = a; i_req1_opB = b;
        end else begin
            i_req0_valid = 1'b1; i_req0_aluOp = op; i_req0_opA = a; i_req0_opB = b;
        end
    endtask

    task automatic do_op(input string tag, input bit idx, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input bit exp_e);
        i_rsp_ready = 1'b1;
        set_req(idx, op, a, b);
        #1;
        for (int i = 0; i < 8 && !(idx ? o_req1_ready : o_req0_ready); i++) tick;
        check({tag, "_ready"}, idx ? o_req1_ready : o_req0_ready, 1);
        tick;
        if (idx) i_req1_valid = 1'b0; else i_req0_valid = 1'b0;
        for (int i = 0; i < 8 && !o_rsp_valid; i++) tick;
        check({tag, "_valid"}, o_rsp_valid, 1);
        check({tag, "_data"}, o_rsp_data, exp_d);
        check({tag, "_id"}, o_rsp_id, idx);
        check({tag, "_err"}, o_rsp_err, exp_e);
        tick;
    endtask

    initial begin
        int last_rsp;
        int k;
        do_reset;
        chk_en = 1'b1;

        // Single request: fixed two-cycle latency.
        set_req(0, 4'd0, 32'd5, 32'd7);
        #1;
        check("s1_ready0_c0", o_req0_ready, 1);
        tick;
        i_req0_valid = 1'b0;
        #1;
        check("s1_valid_c1", o_rsp_valid, 0);
        tick;
        check("s1_valid_c2", o_rsp_valid, 1);
        check("s1_data", o_rsp_data, 32'd12);
        check("s1_id", o_rsp_id, 0);
        check("s1_err", o_rsp_err, 0);
        tick;
        check("s1_idle_c3", o_busy, 0);

        // Simultaneous requests: req0 first after reset, then req1.
        do_reset;
        set_req(0, 4'd1, 32'd3, 32'd5);
        set_req(1, 4'd2, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("s2_ready0", o_req0_ready, 1);
        check("s2_ready1", o_req1_ready, 0);
        tick;
        i_req0_valid = 1'b0;
        tick;
        check("s2_first_data", o_rsp_data, 32'hFFFF_FFFE);
        check("s2_first_id", o_rsp_id, 0);
        tick;
        check("s2_ready1_after", o_req1_ready, 1);
        tick;
        i_req1_valid = 1'b0;
        tick;
        check("s2_second_data", o_rsp_data, 32'd1);
        check("s2_second_id", o_rsp_id, 1);
        tick;

        // Fairness: both always valid, consumer always ready.
        do_reset;
        set_req(0, 4'd0, $urandom, $urandom);
        set_req(1, 4'd4, $urandom, $urandom);
        k = 0;
        last_rsp = 0;
        for (int c = 0; c < 60 && k < 12; c++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                check("fair_order", o_rsp_id, k % 2);
                if (k > 0) check("fair_gap", cyc - last_rsp, 3);
                last_rsp = cyc;
                k++;
            end
            tick;
            if (m_acc0) set_req(0, 4'($urandom_range(0, 10)), $urandom, $urandom);
            if (m_acc1) set_req(1, 4'($urandom_range(0, 10)), $urandom, $urandom);
        end
        check("fair_count", k, 12);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        tick;
        tick;
        tick;

        // Backpressure: response held for 5 cycles, released on the 6th.
        do_reset;
        set_req(0, 4'd4, 32'h0000_F0F0, 32'h0000_0FF0);
        i_rsp_ready = 1'b0;
        tick;
        i_req0_valid = 1'b0;
        set_req(1, 4'd0, 32'd1, 32'd1);
        for (int i = 0; i < 8 && !o_rsp_valid; i++) tick;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", o_rsp_valid, 1);
            check("bp_data", o_rsp_data, 32'h0000_FF00);
            check("bp_id", o_rsp_id, 0);
            check("bp_ready0", o_req0_ready, 0);
            check("bp_ready1", o_req1_ready, 0);
            tick;
        end
        i_rsp_ready = 1'b1;
        #1;
        check("bp_valid_6th", o_rsp_valid, 1);
        tick;
        check("bp_released", o_rsp_valid, 0);
        check("bp_next_ready1", o_req1_ready, 1);
        tick;
        i_req1_valid = 1'b0;
        tick;
        tick;

        // Reset during EXEC discards the operation.
        do_reset;
        set_req(0, 4'd0, 32'd100, 32'd1);
        tick;
        i_req0_valid = 1'b0;
        set_req(1, 4'd6, 32'hFF, 32'h0F);
        i_reset = 1'b1;
        #1;
        check("rst_busy_exec", o_busy, 1);
        check("rst_ready1_forced", o_req1_ready, 0);
        tick;
        i_reset = 1'b0;
        #1;
        check("rst_idle", o_busy, 0);
        check("rst_no_rsp", o_rsp_valid, 0);
        check("rst_data_clear", o_rsp_data, 0);
        tick;
        check("rst_no_late_rsp", o_rsp_valid, 0);
        i_req1_valid = 1'b0;
        tick;
        do_op("rst_next", 1, 4'd6, 32'hFF, 32'h0F, 32'h0F, 0);

        // Illegal opcode, then a legal one.
        do_op("illegal", 1, 4'b1111, 32'd9, 32'd9, 32'd0, 1);
        do_op("legal", 0, 4'd5, 32'd1, 32'd2, 32'd3, 0);
        do_op("sra", 1, 4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);

        // Randomized traffic with occasional resets and backpressure.
        for (int c = 0; c < 1500; c++) begin
            i_reset     = ($urandom_range(0, 79) == 0);
            i_rsp_ready = ($urandom_range(0, 2) != 0);
            if (!i_req0_valid || m_acc0) begin
                i_req0_valid = $urandom_range(0, 1) == 1;
                i_req0_aluOp = 4'($urandom_range(0, 15));
                i_req0_opA   = $urandom;
                i_req0_opB   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            end
            if (!i_req1_valid || m_acc1) begin
                i_req1_valid = $urandom_range(0, 1) == 1;
                i_req1_aluOp = 4'($urandom_range(0, 15));
                i_req1_opA   = $urandom;
                i_req1_opB   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            end
            tick;
        end

        i_reset = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        tick;
        tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL expose the following ports, one per line: name direction width meaning.
- i_clk input 1: single clock; all state updates on its rising edge.
- i_reset input 1: synchronous, active-high reset.
- i_req0_valid input 1: requester 0 has an operation pending.
- i_req0_opA input 32: requester 0 operand A.
- i_req0_opB input 32: requester 0 operand B.
- i_req0_aluOp input 4: requester 0 ALU opcode.
- o_req0_ready output 1: requester 0 operation accepted this cycle.
- i_req1_valid, i_req1_opA, i_req1_opB, i_req1_aluOp, o_req1_ready: same as requester 0, for requester 1.
- o_rsp_valid output 1: result available.
- i_rsp_ready input 1: consumer takes the result.
- o_rsp_data output 32: ALU result.
- o_rsp_id output 1: requester index that owns the result.
- o_rsp_err output 1: the opcode was illegal.
- o_busy output 1: an operation is in flight (state != IDLE).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high, named i_clk and i_reset.
REQ-003 The block SHALL have no parameters; the number of requesters is fixed at 2.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP.
- IDLE->EXEC on acceptance.
- EXEC->RESP unconditionally.
- RESP->IDLE when i_rsp_ready=1.
REQ-005 In IDLE, grant0 SHALL be i_req0_valid & (prio==0 | !i_req1_valid); grant1 SHALL be i_req1_valid & (prio==1 | !i_req0_valid).
REQ-006 o_reqN_ready SHALL be (state==IDLE) & grantN.
- It is combinational and depends on valid.
- At most one ready is high per cycle.
- In EXEC and RESP both readies SHALL be 0.
REQ-007 On acceptance, the block SHALL latch opA, opB, aluOp and id into operand registers, and prio SHALL become the index of the other requester.
REQ-008 A requester SHALL hold valid and its payload stable until ready; the block does not sample an unaccepted payload.
REQ-009 In EXEC, the latched operands SHALL drive the ALU, and its output SHALL be registered into the response register at the end of EXEC.
REQ-010 Latency SHALL be fixed: acceptance in cycle N gives o_rsp_valid=1 in cycle N+2; peak throughput is one operation per 3 cycles.
REQ-011 In RESP, o_rsp_valid SHALL be 1, and data, id and err SHALL hold stable until the cycle in which i_rsp_ready=1.
REQ-012 When the response is taken, the FSM SHALL return to IDLE, and new acceptance is possible in the following cycle; there is no same-cycle bypass.
REQ-013 The opcode SHALL be legal in the range 0000..1010: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, LUI.
- For an illegal opcode (1011..1111) the operation still completes, with o_rsp_data=0 and o_rsp_err=1.
REQ-014 All arithmetic SHALL be 32-bit; SUB wraps modulo 2^32; shifts use opB[4:0] only.
REQ-015 Outside RESP, o_rsp_valid SHALL be 0, and o_rsp_data, o_rsp_id and o_rsp_err SHALL retain their last registered values.
REQ-016 i_rsp_ready SHALL be ignored outside RESP.

Reset
REQ-017 With i_reset=1 at a clock edge:
- state SHALL become IDLE and prio SHALL become 0.
- o_rsp_data, o_rsp_id and o_rsp_err SHALL become 0.
- o_rsp_valid and o_busy SHALL be 0.
REQ-018 While i_reset=1, both readies SHALL be forced to 0.
REQ-019 A reset in EXEC or RESP SHALL discard the in-flight operation without producing a response.

Structure
REQ-020 A shared package alu_pkg SHALL hold:
- the 4-bit opcode constants ALU_ADD..ALU_LUI;
- ALU_OP_MAX=4'b1010;
- the FSM state enum.
REQ-021 The block SHALL instantiate exactly one sub-module, the existing combinational alu, fed from the operand registers.

Verification
REQ-022 The bench SHALL cover these scenarios.
- Single request: after reset, req0 ADD 5,7 in cycle 0 -> ready0=1 in cycle 0; rsp_valid=1 in cycle 2, data=12, id=0, err=0.
- Simultaneous requests: after reset, req0 SUB 3,5 and req1 SLT 0xFFFFFFFF,1 both valid -> req0 first, data=0xFFFFFFFE; then req1, data=1, id=1.
- Fairness: both requesters valid for 12 ops with rsp_ready=1 -> grant order 0,1,0,1,...; each response exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> valid, data and id stable; both readies 0; released on the 6th cycle.
- Reset mid-operation: reset asserted in EXEC -> no response, state IDLE, prio=0; next req1 accepted normally.
- Illegal opcode: req1 aluOp=4'b1111, opA=9, opB=9 -> rsp data=0, err=1, id=1; next legal op gives err=0.
